dispenser_rest: RTL and testbench
=================================

// Module: dispenser_rest
// PURPOSE
//  Change-return mechanism driver for the drink vending machine. Takes a change
//  amount in coin units from the vending controller and pays it out greedily,
//  one coin at a time, using 2-unit and 1-unit coin tubes. Each coin is a single
//  pulse to the tube solenoid, followed by a wait for the coin-drop sensor.
//  Sits between the vending FSM and the physical change tubes.
// PARAMETERS
//  AMT_W    4   width of the change amount and remaining-amount register
//  TIMEOUT  15  WAIT cycles without coin_done before abort (COIN_TIMEOUT_EN only)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  req        in   1      1-cycle pulse: start a payout of 'amount'
//  amount     in   AMT_W  change to return, in units; sampled only when req=1 in IDLE
//  empty1     in   1      1-unit tube empty sensor (level)
//  empty2     in   1      2-unit tube empty sensor (level)
//  coin_done  in   1      coin-drop sensor pulse: the last fired coin has dropped
//  busy       out  1      high in every state except IDLE
//  out_b1     out  1      1-cycle fire pulse, 1-unit tube
//  out_b2     out  1      1-cycle fire pulse, 2-unit tube
//  done       out  1      1-cycle pulse: payout finished or aborted
//  short      out  AMT_W  units not paid out; updated with done, held until next req
//  err        out  1      set with done on timeout abort; held until next req
// BEHAVIOUR
//  - Reset: state=IDLE, rem=0; busy, out_b1, out_b2, done, err = 0; short = 0.
//    Reset mid-payout aborts immediately. No done pulse is produced.
//  - States: IDLE, SELECT, FIRE, WAIT, FINISH. Outputs are registered.
//  - IDLE: if req=1, latch rem<=amount, clear short and err, go to SELECT.
//  - SELECT: a tube is usable if rem covers its value and the tube is not empty.
//    If rem>=2 and !empty2, choose coin 2. Else if rem>=1 and !empty1, choose coin 1.
//    Else go to FINISH. This covers rem=0 and rem>0 with no usable tube.
//  - FIRE: drive out_b2 or out_b1 high for exactly this one cycle, then go to WAIT.
//    out_b1 and out_b2 are never high together.
//  - WAIT: on coin_done=1, rem<=rem-value of the chosen coin (no underflow is
//    possible), then go to SELECT.
//  - FINISH: done=1 for one cycle and short<=rem, then go to IDLE.
//  - Latency: req sampled at edge 0 gives the first fire pulse during the cycle
//    after edge 2. amount=0 gives done during the cycle after edge 2.
//  - req while busy=1 is ignored. coin_done outside WAIT is ignored.
//  - Empty sensors are sampled only in SELECT. A tube going empty mid-payout
//    affects the next selection only.
//  - Greedy order is fixed. Example: rem=3 with the 2-tube available gives
//    coin 2 then coin 1. A shortfall is reported via short, with err=0.
// CONFIGURATION
//  COIN_TIMEOUT_EN defined: a cycle counter clears on entry to WAIT and increments
//    each WAIT cycle without coin_done. When it reaches TIMEOUT-1 with no coin_done,
//    go to FINISH with err<=1 and short<=rem; the unconfirmed coin is not subtracted.
//    coin_done in that same cycle wins: no abort.
//  COIN_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; err is tied to 0.
// TESTING
//  1 amount=5, tubes full, coin_done 2 cycles after each fire
//      -> out_b2, out_b2, out_b1; then done with short=0, err=0.
//  2 amount=3, empty2=1 -> three out_b1 pulses, no out_b2; done with short=0.
//  3 amount=0 -> done 2 cycles after req, no fire pulses, busy high for 2 cycles.
//  4 amount=4, empty1=1, empty2 rises after the first coin drops
//      -> one out_b2; done with short=2, err=0.
//  5 COIN_TIMEOUT_EN, amount=2, coin_done never asserted
//      -> one out_b2; after TIMEOUT WAIT cycles, done with err=1, short=2.
//      Repeat with coin_done in the last WAIT cycle -> no abort, short=0.
//  6 reset in WAIT, and req pulsed while busy
//      -> after reset all outputs 0 and state IDLE; the busy req is ignored.

Source files
------------

// File: rtl/dispenser_rest_if.sv
// -----------------------------------------------------------------------------
// dispenser_rest_if
// Purpose : groups the handshake and sensor signals between the vending
//           controller / change tubes and the change dispenser.
//           Signal names carry the dispenser's point of view (_i = into the
//           dispenser, _o = out of the dispenser).
// Signals : req_i       start pulse for a payout
//           amount_i    change to return, in coin units
//           empty1_i    1-unit tube empty sensor
//           empty2_i    2-unit tube empty sensor
//           coin_done_i coin-drop sensor pulse
//           busy_o      dispenser not idle
//           out_b1_o    fire pulse, 1-unit tube
//           out_b2_o    fire pulse, 2-unit tube
//           done_o      payout finished / aborted pulse
//           short_o     units not paid out
//           err_o       timeout abort flag
// Modports: master = controller/tube side, slave = dispenser side.
// -----------------------------------------------------------------------------
interface dispenser_rest_if #(
    parameter int AMT_W = 4
);
    logic             req_i;
    logic [AMT_W-1:0] amount_i;
    logic             empty1_i;
    logic             empty2_i;
    logic             coin_done_i;
    logic             busy_o;
    logic             out_b1_o;
    logic             out_b2_o;
    logic             done_o;
    logic [AMT_W-1:0] short_o;
    logic             err_o;

    modport master (
        output req_i, amount_i, empty1_i, empty2_i, coin_done_i,
        input  busy_o, out_b1_o, out_b2_o, done_o, short_o, err_o
    );

    modport slave (
        input  req_i, amount_i, empty1_i, empty2_i, coin_done_i,
        output busy_o, out_b1_o, out_b2_o, done_o, short_o, err_o
    );
endinterface

// File: rtl/dispenser_rest.sv
// -----------------------------------------------------------------------------
// dispenser_rest
// Purpose : change-return driver. Pays out a change amount greedily with
//           2-unit coins first, then 1-unit coins, one coin at a time: a
//           one-cycle solenoid pulse, then a wait for the coin-drop sensor.
//           Units that cannot be paid (tubes empty) are reported on short_o.
// Ports   : clk    system clock, posedge
//           reset  synchronous active-high reset
//           bus    dispenser_rest_if.slave (req/amount/sensors in,
//                  busy/fire pulses/done/short/err out)
// Config  : define COIN_TIMEOUT_EN to abort a payout when the coin-drop sensor
//           stays silent for TIMEOUT WAIT cycles (err_o set, short_o = rem).
//           Without it, WAIT holds indefinitely and err_o is constant 0.
// -----------------------------------------------------------------------------
module dispenser_rest #(
    parameter int AMT_W = 4
`ifdef COIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input logic              clk,
    input logic              reset,
    dispenser_rest_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_FIRE   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);
    localparam logic [AMT_W-1:0] TWO = AMT_W'(2);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             coin2_q, coin2_d;     // chosen coin: 1 = 2-unit, 0 = 1-unit
    logic             busy_q, busy_d;
    logic             out_b1_q, out_b1_d;
    logic             out_b2_q, out_b2_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic             start_s;              // accepted payout request
    logic             timeout_s;            // WAIT abort condition this cycle

    assign start_s = (state_q == S_IDLE) && bus.req_i;

`ifdef COIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;     // payout ended by timeout
    logic             err_q, err_d;

    // coin_done in the final WAIT cycle takes priority over the abort
    assign timeout_s = (state_q == S_WAIT) && !bus.coin_done_i &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

    // Timeout counter and abort flag next-state
    always_comb begin
        cnt_d   = '0;
        abort_d = abort_q;
        if (state_q == S_WAIT && !bus.coin_done_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        if (start_s) begin
            abort_d = 1'b0;
        end else if (timeout_s) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end
    end

    // Error flag is published together with done
    always_comb begin
        err_d = err_q;
        if (start_s) begin
            err_d = 1'b0;
        end else if (state_q == S_FINISH) begin
            err_d = abort_q;
        end else begin
            err_d = err_q;
        end
    end

    // Timeout state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign timeout_s = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            coin2_q  <= 1'b0;
            busy_q   <= 1'b0;
            out_b1_q <= 1'b0;
            out_b2_q <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            coin2_q  <= coin2_d;
            busy_q   <= busy_d;
            out_b1_q <= out_b1_d;
            out_b2_q <= out_b2_d;
            done_q   <= done_d;
            short_q  <= short_d;
        end
    end

    // Next-state logic: greedy coin selection and remaining-amount update
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coin2_d = coin2_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    rem_d   = bus.amount_i;
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                // Empty sensors matter only here; a tube emptying mid-coin
                // only influences the next selection.
                if (rem_q >= TWO && !bus.empty2_i) begin
                    coin2_d = 1'b1;
                    state_d = S_FIRE;
                end else if (rem_q >= ONE && !bus.empty1_i) begin
                    coin2_d = 1'b0;
                    state_d = S_FIRE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.coin_done_i) begin
                    // the selection guaranteed rem covers the coin
                    rem_d   = rem_q - (coin2_q ? TWO : ONE);
                    state_d = S_SELECT;
                end else if (timeout_s) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic; every output is registered, so pulses trail the state by one cycle
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        out_b1_d = (state_q == S_FIRE) && !coin2_q;
        out_b2_d = (state_q == S_FIRE) && coin2_q;
        done_d   = (state_q == S_FINISH);
        short_d  = short_q;
        if (start_s) begin
            short_d = '0;
        end else if (state_q == S_FINISH) begin
            short_d = rem_q;
        end else begin
            short_d = short_q;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.out_b1_o = out_b1_q;
    assign bus.out_b2_o = out_b2_q;
    assign bus.done_o   = done_q;
    assign bus.short_o  = short_q;

endmodule

// File: tb/tb_dispenser_rest.sv
// -----------------------------------------------------------------------------
// tb_dispenser_rest
// Table of payout scenarios (amount, tube sensors, coin-drop delay, expected
// coin counts and shortfall) applied in a loop, followed by hand-written
// sequences for zero amount, short hold/clear, reset mid-payout, req while
// busy and (with COIN_TIMEOUT_EN) the timeout abort.
// -----------------------------------------------------------------------------
module tb_dispenser_rest;

    logic clk;
    logic reset;

    dispenser_rest_if #(.AMT_W(4)) dif ();

    dispenser_rest #(.AMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] amt;
        logic       e1;
        logic       e2;
        logic       e2rise;
        int         dly;
        int         exp_b2;
        int         exp_b1;
        logic [3:0] exp_short;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a payout at the current (posedge+1) point and follows it to done.
    task automatic run_payout(
        input  logic [3:0] amt, input logic e1, input logic e2, input logic e2rise,
        input  int dly, input int inj_cyc,
        output int n_b1, output int n_b2, output int first_cyc, output int done_cyc,
        output int busy_cycles, output int overlap, output logic [3:0] sh,
        output logic er, output logic [3:0] sh1);
        int pend;
        int cyc;
        bit fin;
        n_b1 = 0; n_b2 = 0; first_cyc = -1; done_cyc = -1;
        busy_cycles = 0; overlap = 0; sh = 4'd0; er = 1'b0; sh1 = 4'd0;
        pend = 0; cyc = 0; fin = 1'b0;
        dif.empty1_i = e1; dif.empty2_i = e2; dif.amount_i = amt; dif.req_i = 1'b1;
        dif.coin_done_i = 1'b0;
        while (!fin && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            dif.req_i = 1'b0;
            dif.coin_done_i = 1'b0;
            if (cyc == inj_cyc) begin
                dif.req_i = 1'b1;
                dif.amount_i = 4'd7;
            end
            if (cyc == 1) sh1 = dif.short_o;
            if (dif.busy_o) busy_cycles++;
            if (dif.out_b1_o && dif.out_b2_o) overlap++;
            if (dif.out_b1_o) n_b1++;
            if (dif.out_b2_o) n_b2++;
            if ((dif.out_b1_o || dif.out_b2_o || dif.done_o) && first_cyc < 0) first_cyc = cyc;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dif.coin_done_i = 1'b1;
                    if (e2rise) dif.empty2_i = 1'b1;
                end
            end
            if ((dif.out_b1_o || dif.out_b2_o) && dly > 0) pend = dly;
            if (dif.done_o) begin
                fin = 1'b1;
                done_cyc = cyc;
                sh = dif.short_o;
                er = dif.err_o;
            end
        end
        dif.req_i = 1'b0;
        dif.coin_done_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  int'(dif.busy_o),   0);
        check({tag, "_b1"},    int'(dif.out_b1_o), 0);
        check({tag, "_b2"},    int'(dif.out_b2_o), 0);
        check({tag, "_done"},  int'(dif.done_o),   0);
        check({tag, "_short"}, int'(dif.short_o),  0);
        check({tag, "_err"},   int'(dif.err_o),    0);
    endtask

    initial begin
        int n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap;
        int act_cnt;
        logic [3:0] sh, sh1;
        logic er;

        errors = 0;
        checks = 0;

        //            amt   e1    e2    rise  dly b2 b1 short
        vecs[0] = '{4'd5,  1'b0, 1'b0, 1'b0, 2,  2, 1, 4'd0};
        vecs[1] = '{4'd3,  1'b0, 1'b1, 1'b0, 2,  0, 3, 4'd0};
        vecs[2] = '{4'd0,  1'b0, 1'b0, 1'b0, 2,  0, 0, 4'd0};
        vecs[3] = '{4'd4,  1'b1, 1'b0, 1'b1, 2,  1, 0, 4'd2};
        vecs[4] = '{4'd3,  1'b0, 1'b0, 1'b0, 1,  1, 1, 4'd0};
        vecs[5] = '{4'd15, 1'b1, 1'b1, 1'b0, 2,  0, 0, 4'd15};
        vecs[6] = '{4'd7,  1'b1, 1'b0, 1'b0, 3,  3, 0, 4'd1};
        vecs[7] = '{4'd1,  1'b0, 1'b0, 1'b0, 2,  0, 1, 4'd0};
        vecs[8] = '{4'd1,  1'b1, 1'b0, 1'b0, 2,  0, 0, 4'd1};

        dif.req_i = 1'b0; dif.amount_i = 4'd0; dif.empty1_i = 1'b0;
        dif.empty2_i = 1'b0; dif.coin_done_i = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");

        // Table-driven payouts
        for (int i = 0; i < 9; i++) begin
            run_payout(vecs[i].amt, vecs[i].e1, vecs[i].e2, vecs[i].e2rise, vecs[i].dly, 0,
                       n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
            check($sformatf("v%0d_done_seen", i), int'(done_cyc > 0), 1);
            check($sformatf("v%0d_n_b2", i), n_b2, vecs[i].exp_b2);
            check($sformatf("v%0d_n_b1", i), n_b1, vecs[i].exp_b1);
            check($sformatf("v%0d_short", i), int'(sh), int'(vecs[i].exp_short));
            check($sformatf("v%0d_err", i), int'(er), 0);
            check($sformatf("v%0d_first_event_cyc", i), first_cyc, 3);
            check($sformatf("v%0d_overlap", i), overlap, 0);
            check($sformatf("v%0d_busy_at_done", i), int'(dif.busy_o), 0);
            @(posedge clk); #1;
        end

        // Shortfall from the last vector is held while idle
        repeat (4) @(posedge clk);
        #1;
        check("short_held", int'(dif.short_o), 1);
        check("done_low_idle", int'(dif.done_o), 0);

        // Next req clears short; req injected while busy must be ignored
        run_payout(4'd2, 1'b0, 1'b0, 1'b0, 2, 4,
                   n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
        check("short_cleared_on_req", int'(sh1), 0);
        check("busyreq_n_b2", n_b2, 1);
        check("busyreq_n_b1", n_b1, 0);
        check("busyreq_short", int'(sh), 0);
        act_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dif.busy_o || dif.out_b1_o || dif.out_b2_o || dif.done_o) act_cnt++;
        end
        check("busyreq_no_second_payout", act_cnt, 0);

        // amount=0: done on cycle 3, busy for exactly 2 cycles
        run_payout(4'd0, 1'b0, 1'b0, 1'b0, 2, 0,
                   n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
        check("zero_done_cyc", done_cyc, 3);
        check("zero_busy_cycles", busy_cycles, 2);
        check("zero_fires", n_b1 + n_b2, 0);
        @(posedge clk); #1;

        // Reset while waiting for a coin drop
        dif.amount_i = 4'd4; dif.empty1_i = 1'b0; dif.empty2_i = 1'b0; dif.req_i = 1'b1;
        act_cnt = 0;
        for (int c = 0; c < 10 && act_cnt == 0; c++) begin
            @(posedge clk); #1;
            dif.req_i = 1'b0;
            if (dif.out_b2_o) act_cnt = 1;
        end
        check("rst_wait_fire_seen", act_cnt, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs("rst_wait");
        dif.coin_done_i = 1'b1;
        @(posedge clk); #1;
        dif.coin_done_i = 1'b0;
        act_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dif.busy_o || dif.out_b1_o || dif.out_b2_o || dif.done_o) act_cnt++;
        end
        check("rst_wait_stays_idle", act_cnt, 0);

        // After reset a fresh payout still works
        run_payout(4'd2, 1'b0, 1'b0, 1'b0, 2, 0,
                   n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
        check("post_rst_n_b2", n_b2, 1);
        check("post_rst_first_cyc", first_cyc, 3);
        @(posedge clk); #1;

`ifdef COIN_TIMEOUT_EN
        // No coin drop: abort after 15 WAIT cycles
        run_payout(4'd2, 1'b0, 1'b0, 1'b0, 0, 0,
                   n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
        check("to_n_b2", n_b2, 1);
        check("to_done_cyc", done_cyc, 19);
        check("to_err", int'(er), 1);
        check("to_short", int'(sh), 2);
        @(posedge clk); #1;
        // Coin drop in the last WAIT cycle wins over the abort; err cleared by req
        run_payout(4'd2, 1'b0, 1'b0, 1'b0, 14, 0,
                   n_b1, n_b2, first_cyc, done_cyc, busy_cycles, overlap, sh, er, sh1);
        check("to_last_n_b2", n_b2, 1);
        check("to_last_err", int'(er), 0);
        check("to_last_short", int'(sh), 0);
        check("to_last_done_cyc", done_cyc, 20);
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
